// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for the Johnson counter and its receive-side monitor:
//   - mon_state_e : monitor state encoding (HUNT / CHECK / LOCKED)
//   - JOHNSON_DEFAULT_WIDTH : default Johnson code width
//   - johnson_next() : next code in the Johnson sequence, for any width <= 32
// -----------------------------------------------------------------------------
package johnson_pkg;

    localparam int unsigned JOHNSON_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } mon_state_e;

    // Shift left by one and feed back the inverted MSB into bit 0.
    // The result is masked to 'width' bits so callers can truncate safely.
    function automatic logic [31:0] johnson_next(input logic [31:0] code,
                                                 input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return ((code << 1) & mask) | {31'd0, ~code[width - 32'd1]};
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// -----------------------------------------------------------------------------
// johnson_decode
// Purely combinational Johnson decoder: code -> state index plus legality.
// Ports:
//   i_code  [WIDTH-1:0] : Johnson code under test
//   o_index [IDX_W-1:0] : decoded state index (meaningful only when legal)
//   o_legal             : code is an exact Johnson code
// -----------------------------------------------------------------------------
import johnson_pkg::*;

module johnson_decode #(
    parameter int WIDTH = JOHNSON_DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] i_code,
    output logic [IDX_W-1:0] o_index,
    output logic             o_legal
);

    int               w_ones;
    int               w_idx;
    logic [WIDTH-1:0] w_enc;

    // Popcount decode, then re-encode the index; legal only if it round-trips.
    always_comb begin
        w_ones = 0;
        for (int b = 0; b < WIDTH; b++) begin
            w_ones = w_ones + int'(i_code[b]);
        end
        if (i_code[WIDTH-1]) begin
            w_idx = 2 * WIDTH - w_ones;
        end else begin
            w_idx = w_ones;
        end
        // First half fills ones from bit 0; second half keeps ones in the top bits.
        for (int b = 0; b < WIDTH; b++) begin
            if (w_idx <= WIDTH) begin
                w_enc[b] = (b < w_idx);
            end else begin
                w_enc[b] = (b >= (w_idx - WIDTH));
            end
        end
        o_index = IDX_W'(w_idx);
        o_legal = (w_enc == i_code);
    end

endmodule

// File: rtl/johnson_monitor.sv
// -----------------------------------------------------------------------------
// johnson_monitor
// Receive-side checker for a Johnson counter output bus. Decodes each valid
// sample, flags illegal codes, locks onto a consistent sequence and counts
// sequence / illegal-code errors in a saturating counter. All outputs are
// registered and reflect the previous valid sample.
// Optional build macro: JOHNSON_MON_HOLD_OK_EN -- when defined, a repeated code
// in CHECK or LOCKED is accepted as a counter stall instead of a mismatch.
// Ports:
//   clk           : clock, rising edge
//   rst           : asynchronous active-high reset
//   i_code        : Johnson code under test
//   i_code_valid  : sample enable
//   o_index       : decoded index of the last legal sample
//   o_index_valid : pulse, index updated from a legal sample
//   o_locked      : level, sequence tracked
//   o_seq_err     : pulse, legal out-of-sequence code while locked
//   o_illegal     : pulse, sampled code is not a Johnson code
//   o_err_count   : saturating error total
// -----------------------------------------------------------------------------
import johnson_pkg::*;

module johnson_monitor #(
    parameter int WIDTH      = JOHNSON_DEFAULT_WIDTH,
    parameter int IDX_W      = $clog2(2 * WIDTH),
    parameter int LOCK_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_code,
    input  logic             i_code_valid,
    output logic [IDX_W-1:0] o_index,
    output logic             o_index_valid,
    output logic             o_locked,
    output logic             o_seq_err,
    output logic             o_illegal,
    output logic [ERR_W-1:0] o_err_count
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);

    mon_state_e       r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_expected;
    logic [IDX_W-1:0] r_index;
    logic             r_index_valid;
    logic             r_locked;
    logic             r_seq_err;
    logic             r_illegal;
    logic [ERR_W-1:0] r_err_count;

    mon_state_e       w_state;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_expected;
    logic [WIDTH-1:0] w_next_code;
    logic [IDX_W-1:0] w_index;
    logic [IDX_W-1:0] w_dec_index;
    logic             w_legal;
    logic             w_index_valid;
    logic             w_seq_err;
    logic             w_illegal;
    logic [ERR_W-1:0] w_err_count;
    logic             w_hold;

    johnson_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .i_code  (i_code),
        .o_index (w_dec_index),
        .o_legal (w_legal)
    );

    assign w_next_code = WIDTH'(johnson_next(32'(i_code), WIDTH));
    assign w_cnt_inc   = r_count + CNT_W'(1);

`ifdef JOHNSON_MON_HOLD_OK_EN
    logic [WIDTH-1:0] r_prev_code;

    // Remember the last valid sample so a stalled counter can be recognised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_code <= '0;
        end else if (i_code_valid) begin
            r_prev_code <= i_code;
        end else begin
            r_prev_code <= r_prev_code;
        end
    end

    assign w_hold = (i_code == r_prev_code);
`else
    assign w_hold = 1'b0;
`endif

    // Next-state, tracking and output decode for one valid sample.
    always_comb begin
        w_state       = r_state;
        w_count       = r_count;
        w_expected    = r_expected;
        w_index       = r_index;
        w_index_valid = 1'b0;
        w_seq_err     = 1'b0;
        w_illegal     = 1'b0;
        w_err_count   = r_err_count;
        if (i_code_valid) begin
            if (w_legal) begin
                w_index       = w_dec_index;
                w_index_valid = 1'b1;
            end else begin
                w_illegal = 1'b1;
            end
            case (r_state)
                HUNT: begin
                    if (w_legal) begin
                        w_expected = w_next_code;
                        w_count    = CNT_W'(1);
                        w_state    = (LOCK_COUNT == 1) ? LOCKED : CHECK;
                    end else begin
                        w_state = HUNT;
                    end
                end
                CHECK: begin
                    if (!w_legal) begin
                        w_state = HUNT;
                        w_count = '0;
                    end else if (w_hold) begin
                        w_state = CHECK;
                    end else if (i_code == r_expected) begin
                        w_count    = w_cnt_inc;
                        w_expected = w_next_code;
                        w_state    = (w_cnt_inc == CNT_W'(LOCK_COUNT)) ? LOCKED : CHECK;
                    end else begin
                        // Consistent but different sequence: restart the lock count.
                        w_count    = CNT_W'(1);
                        w_expected = w_next_code;
                    end
                end
                LOCKED: begin
                    if (!w_legal) begin
                        w_state = HUNT;
                        w_count = '0;
                    end else if (w_hold) begin
                        w_state = LOCKED;
                    end else if (i_code == r_expected) begin
                        w_expected = w_next_code;
                    end else begin
                        w_seq_err = 1'b1;
                        w_state   = HUNT;
                        w_count   = '0;
                    end
                end
                default: begin
                    w_state = HUNT;
                    w_count = '0;
                end
            endcase
            // At most one increment per sample; never wrap past all-ones.
            if ((w_seq_err || w_illegal) && (r_err_count != {ERR_W{1'b1}})) begin
                w_err_count = r_err_count + ERR_W'(1);
            end else begin
                w_err_count = r_err_count;
            end
        end else begin
            w_state = r_state;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= HUNT;
            r_count       <= '0;
            r_expected    <= '0;
            r_index       <= '0;
            r_index_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_seq_err     <= 1'b0;
            r_illegal     <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_state       <= w_state;
            r_count       <= w_count;
            r_expected    <= w_expected;
            r_index       <= w_index;
            r_index_valid <= w_index_valid;
            r_locked      <= (w_state == LOCKED);
            r_seq_err     <= w_seq_err;
            r_illegal     <= w_illegal;
            r_err_count   <= w_err_count;
        end
    end

    assign o_index       = r_index;
    assign o_index_valid = r_index_valid;
    assign o_locked      = r_locked;
    assign o_seq_err     = r_seq_err;
    assign o_illegal     = r_illegal;
    assign o_err_count   = r_err_count;

endmodule
